// File: rtl/temporizador_pkg.sv
// Shared constants and helpers for the BCD countdown timer.
package temporizador_pkg;

    // FSM state encodings (2-bit)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Largest legal BCD digit value
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Ceiling log2, used to size the prescaler counter
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Saturate a nibble to a legal BCD digit
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digito_dec.sv
// One BCD digit of the countdown chain: loadable, decrements on an incoming
// borrow and wraps 0 -> 9 while passing the borrow to the next digit.
module bcd_digito_dec
    import temporizador_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] data,
    input  logic       dec_en,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       is_zero,
    output logic       borrow_out
);

    assign is_zero    = (digit == 4'd0);
    assign borrow_out = borrow_in & is_zero;

    // Digit register: load wins, otherwise decrement when a borrow reaches us
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= data;
        end else if (dec_en && borrow_in) begin
            digit <= is_zero ? BCD_MAX : (digit - 4'd1);
        end
    end

endmodule

// File: rtl/temporizador_bcd.sv
// N-digit synchronous BCD countdown timer with prescaler, start/pause,
// optional auto-reload, run/done status and a one-cycle timeout pulse.
//
// Control inputs are plain levels sampled on every rising edge; there is no
// valid/ready handshake. load beats everything; start is ignored with a zero
// count or when pause is also high.
module temporizador_bcd
    import temporizador_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  auto_reload,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  timeout,
    output logic                  running,
    output logic                  done,
    output logic [1:0]            state_dbg
);

    localparam int              PS_W    = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [1:0]          state;
    logic [PS_W-1:0]     prescaler;
    logic [4*DIGITS-1:0] reload_reg;
    logic [4*DIGITS-1:0] load_value;
    logic [4*DIGITS-1:0] digit_data;
    logic [4*DIGITS-1:0] count;
    logic [DIGITS-1:0]   is_zero;
    logic [DIGITS:0]     borrow;
    logic                digit_load;
    logic                tick;
    logic                expiry;
    logic                upper_zero;
    logic                count_zero;
    logic                unused_borrow;

    // Saturate every incoming nibble to 9 before it is stored anywhere
    always_comb begin
        load_value = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_value[4*i +: 4] = clamp_digit(data_in[4*i +: 4]);
        end
    end

    // A tick is only processed in RUN when neither load nor pause pre-empts it
    assign tick       = (state == ST_RUN) && !load && !pause && (prescaler == PS_LAST);
    assign count_zero = &is_zero;
    assign upper_zero = ((count >> 4) == '0);
    assign expiry     = tick && upper_zero && (count[3:0] == 4'd1);

    // Auto-reload replaces the 01 -> 00 step with a direct jump to reload_reg
    assign digit_load = load | (expiry & auto_reload);
    assign digit_data = load ? load_value : reload_reg;
    assign borrow[0]  = tick;

    // The top digit never borrows while running (count is never 0 in RUN)
    assign unused_borrow = borrow[DIGITS];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digito_dec u_digit (
                .clk        (clk),
                .reset      (reset),
                .load       (digit_load),
                .data       (digit_data[4*g +: 4]),
                .dec_en     (tick),
                .borrow_in  (borrow[g]),
                .digit      (count[4*g +: 4]),
                .is_zero    (is_zero[g]),
                .borrow_out (borrow[g+1])
            );
        end
    endgenerate

    // Prescaler: cleared by load, counts in RUN, holds while paused to keep phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (load) begin
            prescaler <= '0;
        end else if ((state == ST_RUN) && !pause) begin
            prescaler <= (prescaler == PS_LAST) ? '0 : (prescaler + PS_W'(1));
        end
    end

    // Reload value captured (clamped) on every load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload_reg <= '0;
        end else if (load) begin
            reload_reg <= load_value;
        end
    end

    // Timeout pulse lines up with bcd_out showing the post-expiry value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout <= 1'b0;
        end else begin
            timeout <= expiry;
        end
    end

    // Control FSM: IDLE/PAUSED wait for start, RUN counts, DONE waits for load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else if (load) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_PAUSED: begin
                    if (start && !pause && !count_zero) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state <= ST_PAUSED;
                    end else if (expiry && !auto_reload) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd_out   = count;
    assign running   = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_temporizador_bcd.sv
// Bench for temporizador_bcd (DIGITS=2, PRESCALE=4): directed scenarios
// followed by random traffic, all compared every cycle against a decimal
// reference model of the timer.
module tb_temporizador_bcd;

    localparam int DIGITS   = 2;
    localparam int PRESCALE = 4;
    localparam int W        = 4 * DIGITS;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] bcd_out;
    logic         timeout;
    logic         running;
    logic         done;
    logic [1:0]   state_dbg;

    always #5 clk = ~clk;

    temporizador_bcd #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .data_in     (data_in),
        .start       (start),
        .pause       (pause),
        .auto_reload (auto_reload),
        .bcd_out     (bcd_out),
        .timeout     (timeout),
        .running     (running),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // ---------------- reference model ----------------
    int m_val;      // count as a plain decimal number
    int m_reload;   // reload value, decimal
    int m_phase;    // clocks spent in the current count step
    int m_mode;
    bit m_to;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    function automatic int clamp_val(input logic [W-1:0] d);
        int v;
        int p;
        int nib;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = int'((d >> (4 * i)) & 4'hF);
            if (nib > 9) nib = 9;
            v += nib * p;
            p *= 10;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | (W'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_val = 0; m_reload = 0; m_phase = 0; m_mode = M_IDLE; m_to = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        m_to = 0;
        if (load) begin
            m_val    = clamp_val(data_in);
            m_reload = m_val;
            m_phase  = 0;
            m_mode   = M_IDLE;
        end else if (m_mode == M_IDLE || m_mode == M_PAUSED) begin
            if (start && !pause && m_val != 0) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (pause) begin
                m_mode = M_PAUSED;
            end else begin
                m_phase++;
                if (m_phase == PRESCALE) begin
                    m_phase = 0;
                    if (m_val == 1) begin
                        m_to = 1;
                        if (auto_reload) m_val = m_reload;
                        else begin
                            m_val  = 0;
                            m_mode = M_DONE;
                        end
                    end else begin
                        m_val = m_val - 1;
                    end
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".bcd_out"}, 32'(bcd_out), 32'(to_bcd(m_val)));
        check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
        check({tag, ".running"}, 32'(running), 32'(m_mode == M_RUN));
        check({tag, ".done"},    32'(done),    32'(m_mode == M_DONE));
        check({tag, ".state"},   32'(state_dbg), 32'(m_mode));
    endtask

    // ---------------- driver ----------------
    task automatic step(input string tag, input bit ld, input logic [W-1:0] d,
                        input bit st, input bit ps);
        load = ld; data_in = d; start = st; pause = ps;
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, '0, 0, 0);
    endtask

    // Assert reset mid-cycle and check outputs before the next edge
    task automatic async_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all({tag, ".async"});
        @(posedge clk);
        #1;
        compare_all({tag, ".held"});
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #1;
        compare_all("reset0");
        @(posedge clk);
        #1;
        compare_all("reset1");
        reset = 1'b1;

        // start with a zero count is ignored
        step("zero_start", 0, '0, 1, 0);
        step("zero_start", 0, '0, 1, 0);

        // one-shot 12 -> 00
        step("os_load", 1, 8'h12, 0, 0);
        check("os_load_val", 32'(bcd_out), 32'h12);
        step("os_start", 0, '0, 1, 0);
        idle_steps("os_run", 50);
        check("os_done", 32'(done), 32'd1);
        check("os_zero", 32'(bcd_out), 32'h00);
        step("os_restart", 0, '0, 1, 0);
        step("os_restart", 0, '0, 1, 0);

        // clamp
        step("clamp_3c", 1, 8'h3C, 0, 0);
        check("clamp_3c_val", 32'(bcd_out), 32'h39);
        step("clamp_f0", 1, 8'hF0, 0, 0);
        check("clamp_f0_val", 32'(bcd_out), 32'h90);

        // auto-reload 02,01,02,01...
        auto_reload = 1'b1;
        step("ar_load", 1, 8'h02, 0, 0);
        step("ar_start", 0, '0, 1, 0);
        idle_steps("ar_run", 26);
        check("ar_running", 32'(running), 32'd1);
        auto_reload = 1'b0;

        // pause after 9 RUN cycles, hold 20, resume
        step("pr_load", 1, 8'h05, 0, 0);
        step("pr_start", 0, '0, 1, 0);
        idle_steps("pr_run", 9);
        check("pr_before_pause", 32'(bcd_out), 32'h03);
        for (int i = 0; i < 20; i++) step("pr_pause", 0, '0, 0, 1);
        step("pr_resume", 0, '0, 1, 0);
        idle_steps("pr_after", 4);

        // priorities
        step("pri_load_start", 1, 8'h34, 1, 0);
        step("pri_start", 0, '0, 1, 0);
        idle_steps("pri_run", 2);
        step("pri_start_pause", 0, '0, 1, 1);
        check("pri_paused", 32'(state_dbg), 32'(M_PAUSED));
        step("exp_load", 1, 8'h01, 0, 0);
        step("exp_start", 0, '0, 1, 0);
        idle_steps("exp_run", 3);
        step("exp_pause", 0, '0, 0, 1);
        check("exp_pause_val", 32'(bcd_out), 32'h01);
        check("exp_pause_to", 32'(timeout), 32'd0);

        // reset in the middle of RUN
        step("rst_load", 1, 8'h55, 0, 0);
        step("rst_start", 0, '0, 1, 0);
        idle_steps("rst_run", 6);
        async_reset("rst_mid");
        idle_steps("rst_after", 2);

        // random traffic
        for (int i = 0; i < 700; i++) begin
            logic [W-1:0] d;
            if ($urandom_range(0, 59) == 0) auto_reload = ~auto_reload;
            d = ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 3)) : W'($urandom);
            step("rnd", $urandom_range(0, 29) == 0, d,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            if (i == 350) async_reset("rnd_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
